// File: rtl/gate_response_checker_pkg.sv
// gate_chk_pkg: shared state encoding and 2-input gate truth tables indexed by {in1,in2}
package gate_chk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: stimulus strobe (start/sample/in1/in2/out_obs) from master, run status and results back from the checker
interface gate_response_checker_if #(parameter int ERR_W = 8);
  logic start, sample, in1, in2, out_obs;
  logic busy, done, pass, timeout, first_err_valid;
  logic [ERR_W-1:0] err_count;
  logic [3:0] cov_mask;
  logic [2:0] first_err_vec;
  modport master(output start, sample, in1, in2, out_obs,
                 input busy, done, pass, timeout, err_count, cov_mask, first_err_vec, first_err_valid);
  modport slave(input start, sample, in1, in2, out_obs,
                output busy, done, pass, timeout, err_count, cov_mask, first_err_vec, first_err_valid);
endinterface

// File: rtl/gate_response_checker_sat_counter.sv
// sat_counter: W-bit counter with sync clear and saturating increment; ports clk, rst, clr, inc, count, nxt (next-state value)
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] nxt
);
  assign nxt = clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
  always_ff @(posedge clk) count <= rst ? '0 : nxt;
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: checks sampled 2-input gate responses against TT, tracks coverage/errors, ends on full coverage or timeout; ports clk, reset, bus (slave)
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TT      = TT_XNOR,
  parameter int         ERR_W   = 8,
  parameter int         TIMEOUT = 1000,
  parameter int         TO_W    = 16
) (
  input logic clk,
  input logic reset,
  gate_response_checker_if.slave bus
);
  state_t state;
  logic [TO_W-1:0] tcnt;
  logic [1:0] idx;
  logic hit, mism, cov_full;
  logic [3:0] cov_next;
  logic [ERR_W-1:0] err_next;
  assign idx      = {bus.in1, bus.in2};
  assign hit      = state == RUN && !bus.start && bus.sample;
  assign mism     = hit && bus.out_obs != TT[idx];
  assign cov_next = bus.cov_mask | (hit ? 4'b0001 << idx : 4'b0000);
  assign cov_full = cov_next == 4'b1111;
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst(reset), .clr(bus.start), .inc(mism), .count(bus.err_count), .nxt(err_next)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {bus.busy, bus.done, bus.pass, bus.timeout, bus.first_err_valid} <= '0;
      bus.cov_mask <= '0;
      bus.first_err_vec <= '0;
      tcnt <= '0;
    end else if (bus.start) begin
      state <= RUN;
      bus.busy <= 1'b1;
      {bus.done, bus.pass, bus.timeout, bus.first_err_valid} <= '0;
      bus.cov_mask <= '0;
      bus.first_err_vec <= '0;
      tcnt <= '0;
    end else if (state == RUN) begin
      bus.cov_mask <= cov_next;
      tcnt <= tcnt + 1'b1;
      if (mism && !bus.first_err_valid) begin
        bus.first_err_vec <= {idx, bus.out_obs};
        bus.first_err_valid <= 1'b1;
      end
      // completing coverage on the last timeout cycle still counts as a clean finish
      if (cov_full || tcnt == TO_W'(TIMEOUT - 1)) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.timeout <= !cov_full;
        bus.pass <= cov_full && err_next == '0;
      end
    end
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: directed checks of the XNOR checker (long timeout) and a TIMEOUT=20 instance
module tb_gate_response_checker;
  logic clk = 1'b0, reset = 1'b1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gate_response_checker_if #(.ERR_W(8)) ifa();
  gate_response_checker_if #(.ERR_W(8)) ifb();
  gate_response_checker #(.TT(4'b1001), .ERR_W(8), .TIMEOUT(1000), .TO_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  gate_response_checker #(.TT(4'b1001), .ERR_W(8), .TIMEOUT(20), .TO_W(16)) u_to (
    .clk(clk), .reset(reset), .bus(ifb.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic a, input logic b, input logic o);
    {ifa.in1, ifa.in2, ifa.out_obs, ifa.sample} = {a, b, o, 1'b1};
    {ifb.in1, ifb.in2, ifb.out_obs, ifb.sample} = {a, b, o, 1'b1};
    tick();
    ifa.sample = 1'b0;
    ifb.sample = 1'b0;
  endtask
  task automatic go();
    ifa.start = 1'b1;
    ifb.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask
  initial begin
    {ifa.start, ifa.sample, ifa.in1, ifa.in2, ifa.out_obs} = '0;
    {ifb.start, ifb.sample, ifb.in1, ifb.in2, ifb.out_obs} = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_pass", ifa.pass, 0);
    chk("rst_timeout", ifa.timeout, 0);
    chk("rst_err", ifa.err_count, 0);
    chk("rst_cov", ifa.cov_mask, 0);
    chk("rst_fev", ifa.first_err_vec, 0);
    chk("rst_fevv", ifa.first_err_valid, 0);
    smp(1'b0, 1'b0, 1'b0);
    chk("idle_ignore_cov", ifa.cov_mask, 0);
    chk("idle_ignore_err", ifa.err_count, 0);
    go();
    chk("t1_busy", ifa.busy, 1);
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 0);
    chk("t1_cov3", ifa.cov_mask, 4'b0111);
    chk("t1_notdone3", ifa.done, 0);
    smp(1, 1, 1);
    chk("t1_done", ifa.done, 1);
    chk("t1_busy0", ifa.busy, 0);
    chk("t1_pass", ifa.pass, 1);
    chk("t1_err", ifa.err_count, 0);
    chk("t1_cov", ifa.cov_mask, 4'b1111);
    chk("t1_fevv", ifa.first_err_valid, 0);
    chk("t1_timeout", ifa.timeout, 0);
    smp(0, 0, 0);
    chk("done_frozen_err", ifa.err_count, 0);
    chk("done_frozen_pass", ifa.pass, 1);
    go();
    chk("t2_cleared_cov", ifa.cov_mask, 0);
    chk("t2_cleared_done", ifa.done, 0);
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 1); smp(1, 1, 1);
    chk("t2_done", ifa.done, 1);
    chk("t2_pass", ifa.pass, 0);
    chk("t2_err", ifa.err_count, 1);
    chk("t2_fev", ifa.first_err_vec, 3'b101);
    chk("t2_fevv", ifa.first_err_valid, 1);
    go();
    smp(0, 0, 1); smp(1, 1, 1);
    repeat (17) tick();
    chk("t3_notdone19", ifb.done, 0);
    tick();
    chk("t3_done20", ifb.done, 1);
    chk("t3_timeout", ifb.timeout, 1);
    chk("t3_pass", ifb.pass, 0);
    chk("t3_cov", ifb.cov_mask, 4'b1001);
    chk("t3_long_still_busy", ifa.busy, 1);
    go();
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 0);
    repeat (16) tick();
    chk("t3b_notdone", ifb.done, 0);
    smp(1, 1, 1);
    chk("t3b_done", ifb.done, 1);
    chk("t3b_timeout", ifb.timeout, 0);
    chk("t3b_pass", ifb.pass, 1);
    go();
    repeat (254) smp(0, 1, 1);
    chk("t4_err254", ifa.err_count, 254);
    smp(0, 1, 1);
    chk("t4_err255", ifa.err_count, 255);
    repeat (45) smp(0, 1, 1);
    chk("t4_sat", ifa.err_count, 255);
    smp(0, 0, 1); smp(1, 0, 0); smp(1, 1, 1);
    chk("t4_done", ifa.done, 1);
    chk("t4_err_final", ifa.err_count, 255);
    chk("t4_fev", ifa.first_err_vec, 3'b011);
    chk("t4_pass", ifa.pass, 0);
    go();
    smp(0, 0, 1); smp(0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", ifa.busy, 0);
    chk("t5_done", ifa.done, 0);
    chk("t5_cov", ifa.cov_mask, 0);
    chk("t5_err", ifa.err_count, 0);
    smp(1, 0, 0); smp(1, 1, 1);
    chk("t5_ignored_cov", ifa.cov_mask, 0);
    go();
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 0); smp(1, 1, 1);
    chk("t5_pass", ifa.pass, 1);
    chk("t5_done_after", ifa.done, 1);
    go();
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 0);
    {ifa.in1, ifa.in2, ifa.out_obs, ifa.sample, ifa.start} = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tick();
    {ifa.sample, ifa.start} = 2'b00;
    chk("t6_restart_cov", ifa.cov_mask, 0);
    chk("t6_restart_err", ifa.err_count, 0);
    chk("t6_restart_busy", ifa.busy, 1);
    smp(1, 1, 1);
    chk("t6_cov", ifa.cov_mask, 4'b1000);
    chk("t6_notdone", ifa.done, 0);
    {ifa.start, ifb.start} = 2'b11;
    reset = 1'b1;
    tick();
    {ifa.start, ifb.start} = 2'b00;
    reset = 1'b0;
    chk("rst_wins_busy", ifa.busy, 0);
    chk("rst_wins_cov", ifa.cov_mask, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response monitor for 2-input gate blocks (XNOR, XOR, AND and similar). It is the receiving end of the stimulus sequences our test fixtures drive.
- On each sample strobe it captures the stimulus pair and the DUT output, and compares the output against a parameterised truth table.
- It tracks which of the four input combinations have been covered, counts mismatches and records the first failure.
- It declares pass/fail once coverage is complete or a timeout expires. Used in FPGA-level bring-up of gate modules without a simulator.

Parameters:
- TT, 4'b1001, expected output truth table indexed by {in1,in2}. Default is XNOR; XOR=4'b0110, AND=4'b1000.
- ERR_W, 8, width of the mismatch counter (saturating).
- TIMEOUT, 1000, clock cycles in RUN before declaring failure if coverage is incomplete. Must be ≥1.
- TO_W, 16, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears results and begins a check run
- sample  in  1  strobe; in1/in2/out_obs are valid this cycle
- in1  in  1  stimulus bit A applied to the DUT
- in2  in  1  stimulus bit B applied to the DUT
- out_obs  in  1  DUT output corresponding to in1/in2
- busy  out  1  high while in RUN
- done  out  1  high in DONE, held until start or reset
- pass  out  1  valid when done: 1 iff err_count==0 and cov_mask==4'b1111
- timeout  out  1  valid when done: run ended by TIMEOUT
- err_count  out  ERR_W  number of mismatching samples, saturates at all-ones
- cov_mask  out  4  bit {in1,in2} set once that combination has been sampled
- first_err_vec  out  3  {in1,in2,out_obs} of the first mismatch
- first_err_valid  out  1  first_err_vec holds a captured mismatch

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE.
  - busy=0, done=0, pass=0, timeout=0.
  - err_count=0, cov_mask=0, first_err_vec=0, first_err_valid=0, timeout counter=0.
- States:
  - IDLE: samples ignored. start → RUN, clearing all result registers in the same edge.
  - RUN: busy=1.
    - sample=1: idx={in1,in2}; cov_mask[idx]<=1.
    - If out_obs != TT[idx]: err_count increments (saturating).
    - If first_err_valid==0 on a mismatch: first_err_vec<={in1,in2,out_obs} and first_err_valid<=1.
    - Timeout counter increments every RUN cycle.
  - DONE: done=1, busy=0, outputs frozen; samples ignored. start → RUN with a full clear. Results remain readable until then.
- RUN → DONE transitions:
  - Coverage complete: when cov_mask, including the current sample's update, equals 4'b1111, the transition takes effect on the next edge. The completing sample is counted.
  - Timeout: when the counter reaches TIMEOUT-1 with coverage incomplete → DONE with timeout=1. A sample on that same cycle is still processed. If it completes coverage, timeout=0 (coverage wins).
- pass is registered on entry to DONE: pass = (err_count_next==0) && (cov_mask_next==4'b1111).
- Latency: sample at edge N → cov_mask/err_count visible after edge N. done is high after the same edge when that sample completes coverage.
- Coverage only: duplicate samples of an already-covered combination are still checked and still counted as errors.
- start while in RUN: restart. All results are cleared and the timeout counter returns to 0. A sample in the same cycle is discarded.
- Simultaneous start and reset: reset wins.
- Reset mid-run: run aborted, returns to IDLE, no done pulse.
- err_count saturation: holds at 2^ERR_W-1 and never wraps.

Decomposition:
- Shared package gate_chk_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - truth-table constants TT_AND, TT_OR, TT_XOR, TT_XNOR, TT_NAND, TT_NOR.
- One natural sub-module: sat_counter (parameterised width, clear/inc, saturating). Used for err_count; the timeout counter uses a plain increment.

Test Plan:
- Default TT: start, then samples (0,0,1),(0,1,0),(1,0,0),(1,1,1) on consecutive cycles → done one edge after the 4th sample; pass=1, err_count=0, cov_mask=1111, first_err_valid=0.
- Same sequence with (1,0,1) in place of (1,0,0) → done=1, pass=0, err_count=1, first_err_vec=3'b101, first_err_valid=1.
- Start, then only (0,0,1),(1,1,1) with TIMEOUT=20 → done at cycle 20 after start; timeout=1, pass=0, cov_mask=1001.
- Feed 300 samples of (0,1,1) with ERR_W=8, then the remaining combinations correctly → err_count=255 (saturated), first_err_vec=3'b011, pass=0.
- Assert reset after 2 of 4 samples → next cycle all outputs 0, state IDLE. Later samples are ignored until start; a full sequence after start → pass=1.
- start during RUN after 3 correct samples, then one (1,1,1) → cov_mask=1000, not done: the restart cleared prior coverage.
